// File: rtl/data_cache_wt.sv
// data_cache_wt: direct-mapped, write-through, no-write-allocate data cache for the MEM stage.
// Read hits complete combinationally; read misses and every store go through the backing memory.
module data_cache_wt #(
    parameter int INDEX_BITS = 6
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] data_addr,
    input  logic [31:0] data_in,
    input  logic        mem_read,
    input  logic        mem_write,
    output logic [31:0] data_out,
    output logic        stall,
    output logic        bm_req,
    output logic        bm_we,
    output logic [31:0] bm_addr,
    output logic [31:0] bm_wdata,
    input  logic        bm_ack,
    input  logic [31:0] bm_rdata,
    output logic [1:0]  dbgState
);
    localparam int LINES    = 1 << INDEX_BITS;
    localparam int TAG_BITS = 30 - INDEX_BITS;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RD_MISS = 2'd1,
        WR_THRU = 2'd2
    } cacheState_t;

    cacheState_t state;

    logic [LINES-1:0]    validBits;
    logic [TAG_BITS-1:0] tagRam  [LINES];
    logic [31:0]         dataRam [LINES];

    logic [INDEX_BITS-1:0] reqIndex;
    logic [INDEX_BITS-1:0] latIndex;
    logic [TAG_BITS-1:0]   reqTag;
    logic [TAG_BITS-1:0]   latTag;
    logic                  reqHit;
    logic                  latHit;
    logic                  unusedAddrBits;

    // Backing-memory handshake: bm_req is held with bm_addr/bm_we/bm_wdata stable until a
    // one-cycle bm_ack; the transfer completes on the edge where bm_req & bm_ack are both 1.
    assign reqIndex       = data_addr[INDEX_BITS+1:2];
    assign reqTag         = data_addr[31:INDEX_BITS+2];
    assign reqHit         = validBits[reqIndex] && (tagRam[reqIndex] == reqTag);
    assign latIndex       = bm_addr[INDEX_BITS+1:2];
    assign latTag         = bm_addr[31:INDEX_BITS+2];
    assign latHit         = validBits[latIndex] && (tagRam[latIndex] == latTag);
    assign unusedAddrBits = ^{data_addr[1:0], bm_addr[1:0]};
    assign dbgState       = state;

    always_comb begin
        stall    = 1'b0;
        data_out = 32'd0;
        if (reset) begin
            case (state)
                IDLE: begin
                    if (mem_write) begin
                        stall = 1'b1;
                    end else if (mem_read) begin
                        if (reqHit) begin
                            data_out = dataRam[reqIndex];
                        end else begin
                            stall = 1'b1;
                        end
                    end
                end
                RD_MISS: begin
                    stall = ~bm_ack;
                    if (bm_ack) begin
                        data_out = bm_rdata;
                    end
                end
                WR_THRU: stall = ~bm_ack;
                default: stall = 1'b0;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state     <= IDLE;
            bm_req    <= 1'b0;
            bm_we     <= 1'b0;
            bm_addr   <= 32'd0;
            bm_wdata  <= 32'd0;
            validBits <= '0;
        end else begin
            case (state)
                IDLE: begin
                    // A combined read+write is a store: the write branch wins.
                    if (mem_write) begin
                        state    <= WR_THRU;
                        bm_req   <= 1'b1;
                        bm_we    <= 1'b1;
                        bm_addr  <= {data_addr[31:2], 2'b00};
                        bm_wdata <= data_in;
                    end else if (mem_read && !reqHit) begin
                        state   <= RD_MISS;
                        bm_req  <= 1'b1;
                        bm_we   <= 1'b0;
                        bm_addr <= {data_addr[31:2], 2'b00};
                    end
                end
                RD_MISS: begin
                    if (bm_ack) begin
                        validBits[latIndex] <= 1'b1;
                        state               <= IDLE;
                        bm_req              <= 1'b0;
                    end
                end
                WR_THRU: begin
                    if (bm_ack) begin
                        state  <= IDLE;
                        bm_req <= 1'b0;
                    end
                end
                default: begin
                    state  <= IDLE;
                    bm_req <= 1'b0;
                end
            endcase
        end
    end

    // Tag/data arrays carry no reset; the valid bits alone decide whether a line is live.
    always_ff @(posedge clk) begin
        if (reset && bm_ack) begin
            if (state == RD_MISS) begin
                tagRam[latIndex]  <= latTag;
                dataRam[latIndex] <= bm_rdata;
            end else if (state == WR_THRU && latHit) begin
                dataRam[latIndex] <= bm_wdata;
            end
        end
    end
endmodule

// File: tb/tb_data_cache_wt.sv
// Self-checking bench for data_cache_wt: a cycle-by-cycle cache/transaction model plus
// directed transactions with hand-computed expectations.
module tb_data_cache_wt;
    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [31:0] data_addr = 32'd0;
    logic [31:0] data_in = 32'd0;
    logic        mem_read = 1'b0;
    logic        mem_write = 1'b0;
    logic [31:0] data_out;
    logic        stall;
    logic        bm_req;
    logic        bm_we;
    logic [31:0] bm_addr;
    logic [31:0] bm_wdata;
    logic        bm_ack = 1'b0;
    logic [31:0] bm_rdata = 32'd0;
    logic [1:0]  dbgState;

    int testsRun = 0;
    int testsFailed = 0;
    logic [31:0] exp_q[$];

    always #5 clk = ~clk;

    data_cache_wt #(.INDEX_BITS(6)) dut (
        .clk(clk), .reset(reset), .data_addr(data_addr), .data_in(data_in),
        .mem_read(mem_read), .mem_write(mem_write), .data_out(data_out), .stall(stall),
        .bm_req(bm_req), .bm_we(bm_we), .bm_addr(bm_addr), .bm_wdata(bm_wdata),
        .bm_ack(bm_ack), .bm_rdata(bm_rdata), .dbgState(dbgState)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        testsRun++;
        if (act !== exp) begin
            testsFailed++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    // Model: 64 one-word lines, plus at most one outstanding backing-memory transaction.
    bit          mValid [64];
    logic [23:0] mTag   [64];
    logic [31:0] mData  [64];
    bit          busy = 1'b0;
    bit          busyWe = 1'b0;
    logic [31:0] busyAddr = 32'd0;
    logic [31:0] busyData = 32'd0;

    always @(negedge clk) begin
        int unsigned idx;
        logic [23:0] tag;
        bit          mHit;
        logic        expStall;
        logic [31:0] expOut;
        bit          checkOut;
        idx      = (data_addr >> 2) % 64;
        tag      = 24'(data_addr >> 8);
        mHit     = mValid[idx] && (mTag[idx] == tag);
        expStall = 1'b0;
        expOut   = 32'd0;
        checkOut = 1'b1;
        if (!reset) begin
            expStall = 1'b0;
        end else if (!busy) begin
            check("model idle bm_req", {31'd0, bm_req}, 32'd0);
            if (mem_write) expStall = 1'b1;
            else if (mem_read) begin
                expStall = !mHit;
                expOut   = mHit ? mData[idx] : 32'd0;
            end
        end else begin
            check("model busy bm_req", {31'd0, bm_req}, 32'd1);
            check("model bm_we", {31'd0, bm_we}, {31'd0, busyWe});
            check("model bm_addr", bm_addr, busyAddr);
            if (busyWe) check("model bm_wdata", bm_wdata, busyData);
            expStall = !bm_ack;
            if (busyWe) checkOut = 1'b0;
            else expOut = bm_ack ? bm_rdata : 32'd0;
        end
        check("model stall", {31'd0, stall}, {31'd0, expStall});
        if (checkOut) check("model data_out", data_out, expOut);

        // Advance the model to the state after the coming rising edge.
        if (!reset) begin
            busy = 1'b0;
            for (int i = 0; i < 64; i++) mValid[i] = 1'b0;
        end else if (!busy) begin
            if (mem_write) begin
                busy = 1'b1; busyWe = 1'b1;
                busyAddr = data_addr & ~32'd3; busyData = data_in;
            end else if (mem_read && !mHit) begin
                busy = 1'b1; busyWe = 1'b0;
                busyAddr = data_addr & ~32'd3;
            end
        end else if (bm_ack) begin
            busy = 1'b0;
            idx  = (busyAddr >> 2) % 64;
            tag  = 24'(busyAddr >> 8);
            if (!busyWe) begin
                mValid[idx] = 1'b1; mTag[idx] = tag; mData[idx] = bm_rdata;
            end else if (mValid[idx] && mTag[idx] == tag) begin
                mData[idx] = busyData;
            end
        end
    end

    task automatic stepCycle();
        @(posedge clk);
        #1;
    endtask

    task automatic doRead(input logic [31:0] addr, input logic [31:0] value, input bit expMiss,
                          input int ackDelay, input bit perturb, input string name);
        int stallCycles;
        stepCycle();
        data_addr = addr; mem_read = 1'b1; mem_write = 1'b0; bm_ack = 1'b0;
        exp_q.push_back(value);
        @(negedge clk);
        check({name, " first stall"}, {31'd0, stall}, {31'd0, expMiss});
        check({name, " first bm_req"}, {31'd0, bm_req}, 32'd0);
        if (!expMiss) begin
            check({name, " hit data"}, data_out, exp_q.pop_front());
        end else begin
            stallCycles = stall ? 1 : 0;
            for (int c = 1; c < ackDelay; c++) begin
                stepCycle();
                if (perturb && c == 5) begin
                    data_addr = addr ^ 32'h0000_0F04; data_in = $urandom;
                end
                if (perturb && c == ackDelay - 1) data_addr = addr;
                @(negedge clk);
                if (stall) stallCycles++;
            end
            stepCycle();
            bm_ack = 1'b1; bm_rdata = value;
            @(negedge clk);
            check({name, " ack bm_req"}, {31'd0, bm_req}, 32'd1);
            check({name, " ack bm_addr"}, bm_addr, addr & ~32'd3);
            check({name, " ack stall"}, {31'd0, stall}, 32'd0);
            check({name, " ack data"}, data_out, exp_q.pop_front());
            check({name, " stall cycles"}, stallCycles, ackDelay);
        end
        stepCycle();
        mem_read = 1'b0; bm_ack = 1'b0;
    endtask

    task automatic doWrite(input logic [31:0] addr, input logic [31:0] value, input int ackDelay,
                           input bit alsoRead, input string name);
        int stallCycles;
        stepCycle();
        data_addr = addr; data_in = value; mem_write = 1'b1; mem_read = alsoRead; bm_ack = 1'b0;
        @(negedge clk);
        check({name, " first stall"}, {31'd0, stall}, 32'd1);
        if (alsoRead) check({name, " rd+wr data_out"}, data_out, 32'd0);
        stallCycles = stall ? 1 : 0;
        for (int c = 1; c < ackDelay; c++) begin
            stepCycle();
            @(negedge clk);
            if (stall) stallCycles++;
        end
        stepCycle();
        bm_ack = 1'b1;
        @(negedge clk);
        check({name, " bm_req"}, {31'd0, bm_req}, 32'd1);
        check({name, " bm_we"}, {31'd0, bm_we}, 32'd1);
        check({name, " bm_addr"}, bm_addr, addr & ~32'd3);
        check({name, " bm_wdata"}, bm_wdata, value);
        check({name, " ack stall"}, {31'd0, stall}, 32'd0);
        check({name, " stall cycles"}, stallCycles, ackDelay);
        stepCycle();
        mem_write = 1'b0; mem_read = 1'b0; bm_ack = 1'b0;
    endtask

    initial begin
        // Reset with a load pending: outputs must stay quiet.
        data_addr = 32'h100; mem_read = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset stall", {31'd0, stall}, 32'd0);
        check("reset data_out", data_out, 32'd0);
        check("reset bm_req", {31'd0, bm_req}, 32'd0);
        check("reset bm_we", {31'd0, bm_we}, 32'd0);
        check("reset bm_addr", bm_addr, 32'd0);
        check("reset bm_wdata", bm_wdata, 32'd0);
        stepCycle();
        mem_read = 1'b0; reset = 1'b1;

        doRead(32'h100, 32'hDEADBEEF, 1'b1, 3, 1'b0, "t1 miss");
        doRead(32'h100, 32'hDEADBEEF, 1'b0, 0, 1'b0, "t1 hit");

        doWrite(32'h100, 32'h12345678, 2, 1'b0, "t2 write hit");
        doRead(32'h100, 32'h12345678, 1'b0, 0, 1'b0, "t2 reread");
        doRead(32'h103, 32'h12345678, 1'b0, 0, 1'b0, "t2 byte offset");

        doWrite(32'h200, 32'hA5A5A5A5, 1, 1'b0, "t3 write miss");
        doRead(32'h100, 32'h12345678, 1'b0, 0, 1'b0, "t3 line kept");
        doRead(32'h200, 32'hA5A5A5A5, 1'b1, 2, 1'b0, "t3 read miss");

        doRead(32'h100, 32'h12345678, 1'b1, 1, 1'b0, "t4 conflict a");
        doRead(32'h200, 32'hA5A5A5A5, 1'b1, 1, 1'b0, "t4 conflict b");
        doRead(32'h100, 32'h12345678, 1'b1, 2, 1'b0, "t4 conflict c");

        doRead(32'h0FC, 32'h0BADF00D, 1'b1, 1, 1'b0, "wrap line63");
        doRead(32'h000, 32'h11111111, 1'b1, 1, 1'b0, "wrap line0");
        doRead(32'h0FC, 32'h0BADF00D, 1'b0, 0, 1'b0, "wrap hit63");
        doRead(32'h000, 32'h11111111, 1'b0, 0, 1'b0, "wrap hit0");

        // Reset in the middle of a read miss, followed by a late acknowledge.
        stepCycle();
        data_addr = 32'h300; mem_read = 1'b1;
        stepCycle();
        @(negedge clk);
        check("t5 in miss bm_req", {31'd0, bm_req}, 32'd1);
        stepCycle();
        reset = 1'b0;
        stepCycle();
        reset = 1'b1; mem_read = 1'b0; bm_ack = 1'b1; bm_rdata = 32'h55555555;
        @(negedge clk);
        check("t5 after reset bm_req", {31'd0, bm_req}, 32'd0);
        check("t5 after reset state", {30'd0, dbgState}, 32'd0);
        check("t5 late ack stall", {31'd0, stall}, 32'd0);
        stepCycle();
        bm_ack = 1'b0;
        doRead(32'h300, 32'h77777777, 1'b1, 1, 1'b0, "t5 reread");

        doRead(32'h400, 32'hCAFEF00D, 1'b1, 20, 1'b1, "t6 long miss");
        doWrite(32'h400, 32'h0F0F0F0F, 2, 1'b1, "t6 rd+wr");
        doRead(32'h400, 32'h0F0F0F0F, 1'b0, 0, 1'b0, "t6 reread");

        repeat (2) @(posedge clk);
        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end
endmodule
